// File: rtl/cube_tally_if.sv
// cube_tally_if -- producer handshake and bin read bus for cube_tally.
//   Producer side : in_valid, in_cube[11:0], in_last -> ; <- in_ready
//   Read side     : rd_en, rd_bin[3:0] -> ; <- rd_data[CNT_W-1:0], rd_valid
//   master : the producer / reader driving the block
//   slave  : the cube_tally block itself
interface cube_tally_if #(
    parameter int unsigned CNT_W = 12
);
    logic             in_valid;
    logic [11:0]      in_cube;
    logic             in_last;
    logic             in_ready;
    logic             rd_en;
    logic [3:0]       rd_bin;
    logic [CNT_W-1:0] rd_data;
    logic             rd_valid;

    modport master (
        output in_valid, in_cube, in_last, rd_en, rd_bin,
        input  in_ready, rd_data, rd_valid
    );

    modport slave (
        input  in_valid, in_cube, in_last, rd_en, rd_bin,
        output in_ready, rd_data, rd_valid
    );
endinterface

// File: rtl/cube_tally.sv
// cube_tally -- histogram of cube edge-mask popcounts.
//   Each accepted 12-bit cube is reduced to its popcount (0..12) and the
//   matching bin plus a running total are incremented, saturating at
//   2^CNT_W-1 with a sticky overflow flag. A start pulse clears the tallies
//   and opens collection; the beat tagged in_last ends it, and once the
//   tally pipeline drains the block sits in DONE until the next start.
// Ports:
//   clk      : rising-edge clock
//   rst      : synchronous active-low reset
//   start    : one-cycle pulse, honoured in IDLE and DONE only
//   bus      : cube_tally_if.slave (cube handshake + one-cycle bin read)
//   total    : cubes tallied since the last start
//   busy     : high in COLLECT and FLUSH
//   done     : high in DONE until the next start
//   overflow : sticky, set by any saturated increment
// Optional feature: define CUBE_TALLY_FIFO_EN to place a 4-entry
// {in_last, in_cube} FIFO in front of the popcount stage.
module cube_tally #(
    parameter int unsigned CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    cube_tally_if.slave      bus,
    output logic [CNT_W-1:0] total,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    localparam int unsigned     NUM_BINS = 13;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        FLUSH,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] bin_q [NUM_BINS];
    logic [CNT_W-1:0] bin_d [NUM_BINS];
    logic [CNT_W-1:0] total_q, total_d;
    logic             ovf_q, ovf_d;
    logic             s1_valid_q, s1_valid_d;
    logic [3:0]       s1_pop_q, s1_pop_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;

    logic             accept;
    logic             start_go;
    logic             feed_valid;
    logic [11:0]      feed_cube;
    logic             pipe_empty;

    function automatic logic [3:0] popcount12(input logic [11:0] v);
        logic [3:0] c;
        c = '0;
        for (int unsigned i = 0; i < 12; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    assign accept   = bus.in_valid & bus.in_ready;
    assign start_go = start & ((state_q == IDLE) | (state_q == DONE));

`ifdef CUBE_TALLY_FIFO_EN
    logic [12:0] fifo_mem_q [4];
    logic [12:0] fifo_mem_d [4];
    logic [2:0]  wr_ptr_q, wr_ptr_d;
    logic [2:0]  rd_ptr_q, rd_ptr_d;
    logic        fifo_empty;
    logic        fifo_full;
    logic [12:0] fifo_head;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
    assign fifo_full    = (wr_ptr_q[2] != rd_ptr_q[2]) &&
                          (wr_ptr_q[1:0] == rd_ptr_q[1:0]);
    assign fifo_head    = fifo_mem_q[rd_ptr_q[1:0]];
    assign bus.in_ready = (state_q == COLLECT) & ~fifo_full;
    assign feed_valid   = ~fifo_empty;
    assign feed_cube    = fifo_head[11:0];
    assign pipe_empty   = fifo_empty & ~s1_valid_q;

    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (accept) begin
            fifo_mem_d[wr_ptr_q[1:0]] = {bus.in_last, bus.in_cube};
            wr_ptr_d = wr_ptr_q + 3'd1;
        end
        if (feed_valid) begin
            rd_ptr_d = rd_ptr_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        fifo_mem_q <= fifo_mem_d;
    end
`else
    assign bus.in_ready = (state_q == COLLECT);
    assign feed_valid   = accept;
    assign feed_cube    = bus.in_cube;
    assign pipe_empty   = ~s1_valid_q;
`endif

    // Next-state, tally pipeline and read port.
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        total_d    = total_q;
        ovf_d      = ovf_q;
        s1_valid_d = 1'b0;
        s1_pop_d   = s1_pop_q;
        rd_valid_d = bus.rd_en;
        rd_data_d  = '0;

        case (state_q)
            IDLE, DONE: begin
                if (start_go) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (accept && bus.in_last) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (pipe_empty) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Stage 1: register the popcount of the cube entering the pipeline.
        if (feed_valid) begin
            s1_valid_d = 1'b1;
            s1_pop_d   = popcount12(feed_cube);
        end

        // Stage 2: saturating increment of the selected bin and the total.
        if (s1_valid_q) begin
            for (int unsigned i = 0; i < NUM_BINS; i++) begin
                if (s1_pop_q == 4'(i)) begin
                    if (bin_q[i] == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        bin_d[i] = bin_q[i] + 1'b1;
                    end
                end
            end
            if (total_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                total_d = total_q + 1'b1;
            end
        end

        // Start is only honoured while the pipeline is empty, so the clear
        // cannot collide with a live increment.
        if (start_go) begin
            for (int unsigned i = 0; i < NUM_BINS; i++) begin
                bin_d[i] = '0;
            end
            total_d = '0;
            ovf_d   = 1'b0;
        end

        // Reads sample the registered bins, so a same-cycle update is not
        // yet visible; indices 13..15 fall through to zero.
        if (bus.rd_en) begin
            for (int unsigned i = 0; i < NUM_BINS; i++) begin
                if (bus.rd_bin == 4'(i)) begin
                    rd_data_d = bin_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            for (int unsigned i = 0; i < NUM_BINS; i++) begin
                bin_q[i] <= '0;
            end
            total_q    <= '0;
            ovf_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_pop_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            total_q    <= total_d;
            ovf_q      <= ovf_d;
            s1_valid_q <= s1_valid_d;
            s1_pop_q   <= s1_pop_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign total        = total_q;
    assign overflow     = ovf_q;
    assign busy         = (state_q == COLLECT) | (state_q == FLUSH);
    assign done         = (state_q == DONE);
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_cube_tally.sv
// tb_cube_tally -- directed bench for cube_tally.
//   Instance A uses CNT_W=12, instance B uses CNT_W=4 for saturation.
//   Inputs are driven and outputs sampled on the falling clock edge.
module tb_cube_tally;

    logic clk;
    logic rst;
    logic start_a, start_b;
    logic [11:0] total_a;
    logic [3:0]  total_b;
    logic busy_a, done_a, ovf_a;
    logic busy_b, done_b, ovf_b;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    cube_tally_if #(.CNT_W(12)) ifa ();
    cube_tally_if #(.CNT_W(4))  ifb ();

    cube_tally #(.CNT_W(12)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bus(ifa),
        .total(total_a), .busy(busy_a), .done(done_a), .overflow(ovf_a)
    );

    cube_tally #(.CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bus(ifb),
        .total(total_b), .busy(busy_b), .done(done_b), .overflow(ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout act=running req=finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [11:0] cube;
        logic [3:0]  exp_bin;
    } vec_t;

    vec_t vecs [10];
    int unsigned exp_cnt [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s act=%0h req=%0h", name, act, req);
        end
    endtask

    task automatic start_pulse_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    // Presents a beat and returns one falling edge after it is accepted;
    // in_valid is left high so consecutive calls stream back to back.
    task automatic send_a(input logic [11:0] c, input logic l);
        int unsigned g = 0;
        ifa.in_valid = 1'b1;
        ifa.in_cube  = c;
        ifa.in_last  = l;
        while (!ifa.in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!ifa.in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout act=in_ready_low req=in_ready_high");
        end
        @(negedge clk);
    endtask

    task automatic idle_a();
        ifa.in_valid = 1'b0;
        ifa.in_last  = 1'b0;
    endtask

    task automatic wait_done_a();
        int unsigned g = 0;
        while (!done_a && g < 40) begin
            @(negedge clk);
            g++;
        end
        check("wait_done", {31'd0, done_a}, 32'd1);
    endtask

    task automatic read_a(input logic [3:0] b, input logic [11:0] req, input string name);
        ifa.rd_en  = 1'b1;
        ifa.rd_bin = b;
        @(negedge clk);
        ifa.rd_en  = 1'b0;
        check({name, "_vld"}, {31'd0, ifa.rd_valid}, 32'd1);
        check(name, {20'd0, ifa.rd_data}, {20'd0, req});
    endtask

    initial begin
        vecs[0] = '{12'h000, 4'd0};
        vecs[1] = '{12'h001, 4'd1};
        vecs[2] = '{12'h003, 4'd2};
        vecs[3] = '{12'h800, 4'd1};
        vecs[4] = '{12'hFFF, 4'd12};
        vecs[5] = '{12'hAAA, 4'd6};
        vecs[6] = '{12'h555, 4'd6};
        vecs[7] = '{12'h0F0, 4'd4};
        vecs[8] = '{12'h7FF, 4'd11};
        vecs[9] = '{12'h124, 4'd3};

        rst = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        ifa.in_valid = 1'b0; ifa.in_cube = '0; ifa.in_last = 1'b0;
        ifa.rd_en = 1'b0; ifa.rd_bin = '0;
        ifb.in_valid = 1'b0; ifb.in_cube = '0; ifb.in_last = 1'b0;
        ifb.rd_en = 1'b0; ifb.rd_bin = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_total",   {20'd0, total_a}, 32'd0);
        check("rst_busy",    {31'd0, busy_a}, 32'd0);
        check("rst_done",    {31'd0, done_a}, 32'd0);
        check("rst_ovf",     {31'd0, ovf_a}, 32'd0);
        check("rst_ready",   {31'd0, ifa.in_ready}, 32'd0);
        check("rst_rdvalid", {31'd0, ifa.rd_valid}, 32'd0);
        check("rst_rddata",  {20'd0, ifa.rd_data}, 32'd0);

        // Basic run: 0x007, 0x00F, 0x007(last)
        start_pulse_a();
        check("collect_busy",  {31'd0, busy_a}, 32'd1);
        check("collect_ready", {31'd0, ifa.in_ready}, 32'd1);
        send_a(12'h007, 1'b0);
        send_a(12'h00F, 1'b0);
        send_a(12'h007, 1'b1);
        idle_a();
        check("flush_ready", {31'd0, ifa.in_ready}, 32'd0);
        wait_done_a();
        check("basic_busy",  {31'd0, busy_a}, 32'd0);
        check("basic_total", {20'd0, total_a}, 32'd3);
        check("basic_ovf",   {31'd0, ovf_a}, 32'd0);
        read_a(4'd3, 12'd2, "basic_bin3");
        read_a(4'd4, 12'd1, "basic_bin4");
        check("done_held", {31'd0, done_a}, 32'd1);
        check("done_ready", {31'd0, ifa.in_ready}, 32'd0);

        // Table run: every vector once, then read all 16 bin indices
        for (int i = 0; i < 16; i++) exp_cnt[i] = 0;
        for (int i = 0; i < 10; i++) exp_cnt[vecs[i].exp_bin]++;
        start_pulse_a();
        check("restart_total", {20'd0, total_a}, 32'd0);
        for (int i = 0; i < 10; i++) send_a(vecs[i].cube, (i == 9));
        idle_a();
        wait_done_a();
        check("table_total", {20'd0, total_a}, 32'd10);
        for (int b = 0; b < 16; b++) begin
            read_a(4'(b), 12'(exp_cnt[b]), $sformatf("table_bin%0d", b));
        end
        ifa.rd_en = 1'b0;
        @(negedge clk);
        check("rdvalid_low", {31'd0, ifa.rd_valid}, 32'd0);

        // Streaming: 20 back-to-back beats of 0xFFE
        start_pulse_a();
        for (int i = 0; i < 20; i++) begin
            check($sformatf("stream_ready%0d", i), {31'd0, ifa.in_ready}, 32'd1);
            send_a(12'hFFE, (i == 19));
        end
        idle_a();
        wait_done_a();
        check("stream_total", {20'd0, total_a}, 32'd20);
        read_a(4'd11, 12'd20, "stream_bin11");

        // Read/update collision on bin 3 plus two-cycle latency
        start_pulse_a();
        for (int i = 0; i < 5; i++) send_a(12'h007, 1'b0);
        send_a(12'h007, 1'b1);
        idle_a();
        ifa.rd_en  = 1'b1;
        ifa.rd_bin = 4'd3;
        check("lat_total_pre", {20'd0, total_a}, 32'd5);
        @(negedge clk);
        check("coll_vld",   {31'd0, ifa.rd_valid}, 32'd1);
        check("coll_data",  {20'd0, ifa.rd_data}, 32'd5);
        check("lat_total_post", {20'd0, total_a}, 32'd6);
        @(negedge clk);
        check("reread_data", {20'd0, ifa.rd_data}, 32'd6);
        ifa.rd_bin = 4'd14;
        @(negedge clk);
        check("bin14_vld",  {31'd0, ifa.rd_valid}, 32'd1);
        check("bin14_data", {20'd0, ifa.rd_data}, 32'd0);
        ifa.rd_en = 1'b0;
        @(negedge clk);
        check("rd_idle_vld", {31'd0, ifa.rd_valid}, 32'd0);
        wait_done_a();

        // Start ignored in COLLECT, then reset with a cube in flight
        start_pulse_a();
        for (int i = 0; i < 3; i++) send_a(12'h007, 1'b0);
        idle_a();
        repeat (2) @(negedge clk);
        check("three_total", {20'd0, total_a}, 32'd3);
        start_pulse_a();
        repeat (2) @(negedge clk);
        check("ign_start_total", {20'd0, total_a}, 32'd3);
        check("ign_start_busy",  {31'd0, busy_a}, 32'd1);
        send_a(12'h007, 1'b0);
        idle_a();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_total", {20'd0, total_a}, 32'd0);
        check("mid_rst_ready", {31'd0, ifa.in_ready}, 32'd0);
        check("mid_rst_busy",  {31'd0, busy_a}, 32'd0);
        check("mid_rst_done",  {31'd0, done_a}, 32'd0);
        read_a(4'd3, 12'd0, "mid_rst_bin3");

        // Saturation on the CNT_W=4 instance
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int i = 0; i < 17; i++) begin
            ifb.in_valid = 1'b1;
            ifb.in_cube  = 12'h001;
            ifb.in_last  = (i == 16);
            @(negedge clk);
        end
        ifb.in_valid = 1'b0;
        ifb.in_last  = 1'b0;
        for (int g = 0; g < 20 && !done_b; g++) @(negedge clk);
        check("sat_done",  {31'd0, done_b}, 32'd1);
        check("sat_total", {28'd0, total_b}, 32'd15);
        check("sat_ovf",   {31'd0, ovf_b}, 32'd1);
        ifb.rd_en  = 1'b1;
        ifb.rd_bin = 4'd1;
        @(negedge clk);
        ifb.rd_en = 1'b0;
        check("sat_bin1", {28'd0, ifb.rd_data}, 32'd15);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        check("sat_clr_total", {28'd0, total_b}, 32'd0);
        check("sat_clr_ovf",   {31'd0, ovf_b}, 32'd0);
        ifb.rd_en  = 1'b1;
        ifb.rd_bin = 4'd1;
        @(negedge clk);
        ifb.rd_en = 1'b0;
        check("sat_clr_bin1", {28'd0, ifb.rd_data}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
